// File: rtl/pd_pkg.sv
// Shared types and constants for the packet-decoder receive path.
package pd_pkg;

    typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} pd_state_e;

    localparam logic [7:0] TYPE_SHORT = 8'hA5;
    localparam logic [7:0] TYPE_LONG  = 8'h5A;

    localparam logic [6:0] SHORT_LAST = 7'd61;
    localparam logic [6:0] LONG_LAST  = 7'd110;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TYPE    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/pd_byte_counter.sv
// Payload byte index with a type-dependent last-byte flag.
module pd_byte_counter
    import pd_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       en,
    input  logic       is_long,
    output logic [6:0] count,
    output logic       last_byte
);

    assign last_byte = (count == (is_long ? LONG_LAST : SHORT_LAST));

    // Holds at the last index so the count can never run past the packet.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && !last_byte)
            count <= count + 7'd1;
    end

endmodule

// File: rtl/pd_rx_controller.sv
// Receive sequencer: type byte, payload stream into the byte store,
// inter-byte timeout supervision and consumer handshake.
module pd_rx_controller #(
    parameter int         TO_W           = 16,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [7:0] TYPE_SHORT     = pd_pkg::TYPE_SHORT,
    parameter logic [7:0] TYPE_LONG      = pd_pkg::TYPE_LONG
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       pkt_valid,
    output logic       pkt_long,
    input  logic       pkt_ack,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy
);

    import pd_pkg::*;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    pd_state_e       state;
    logic [TO_W-1:0] to_cnt;
    logic [6:0]      byte_count;
    logic            last_byte;
    logic            accept;
    logic            type_ok;
    logic            timeout;

    assign accept  = rx_valid & rx_ready;
    assign type_ok = (rx_data == TYPE_SHORT) || (rx_data == TYPE_LONG);
    // An accepted byte on the expiry cycle takes priority over the timeout.
    assign timeout = (state == RECV) && !accept && (to_cnt == TO_LAST);
    assign busy    = (state != IDLE);

    pd_byte_counter u_byte_counter (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr       ((state == IDLE && accept) || timeout),
        .en        (state == RECV && accept),
        .is_long   (pkt_long),
        .count     (byte_count),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            rx_ready  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            pkt_valid <= 1'b0;
            pkt_long  <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= ERR_NONE;
            to_cnt    <= '0;
        end else begin
            wr_en    <= 1'b0;
            pkt_err  <= 1'b0;
            err_code <= ERR_NONE;
            case (state)
                IDLE: begin
                    rx_ready <= 1'b1;
                    if (accept) begin
                        if (type_ok) begin
                            pkt_long <= (rx_data == TYPE_LONG);
                            to_cnt   <= '0;
                            state    <= RECV;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= ERR_TYPE;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= byte_count;
                        wr_data <= rx_data;
                        to_cnt  <= '0;
                        if (last_byte) begin
                            rx_ready <= 1'b0;
                            state    <= FLUSH;
                        end
                    end else if (timeout) begin
                        pkt_err  <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        to_cnt   <= '0;
                        state    <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                FLUSH: begin
                    pkt_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (pkt_ack) begin
                        pkt_valid <= 1'b0;
                        rx_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pd_rx_controller.sv
// Directed bench for pd_rx_controller with a write scoreboard.
module tb_pd_rx_controller;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       pkt_ack = 1'b0;
    logic       rx_ready, wr_en, pkt_valid, pkt_long, pkt_err, busy;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] err_code;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int err_seen = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;
    wr_t exp_q[$];

    pd_rx_controller #(
        .TO_W           (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pkt_valid (pkt_valid),
        .pkt_long  (pkt_long),
        .pkt_ack   (pkt_ack),
        .pkt_err   (pkt_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (pkt_err) err_seen++;
        if (wr_en) begin
            chk("wr_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic send_type(input logic [7:0] t);
        rx_valid = 1'b1;
        rx_data  = t;
        chk("type_rdy", rx_ready, 1);
        tick;
        rx_valid = 1'b0;
    endtask

    task automatic send_payload(input int first, input int n, input bit gap);
        for (int i = first; i < first + n; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            chk("pl_rdy", rx_ready, 1);
            exp_q.push_back('{addr: i, data: i, cyc: cyc + 1});
            tick;
            if (gap && i != first + n - 1) begin
                rx_valid = 1'b0;
                tick;
            end
        end
        rx_valid = 1'b0;
    endtask

    // Called in the cycle after the last payload accept (the flush cycle).
    task automatic expect_done(input bit lng);
        chk("flush_rdy", rx_ready, 0);
        chk("flush_valid", pkt_valid, 0);
        chk("flush_busy", busy, 1);
        tick;
        chk("done_valid", pkt_valid, 1);
        chk("done_long", pkt_long, lng);
        chk("done_rdy", rx_ready, 0);
        chk("q_drained", exp_q.size(), 0);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        repeat (3) begin
            tick;
            chk("done_hold_rdy", rx_ready, 0);
            chk("done_hold_valid", pkt_valid, 1);
        end
        rx_valid = 1'b0;
        pkt_ack  = 1'b1;
        tick;
        pkt_ack = 1'b0;
        chk("ack_valid", pkt_valid, 0);
        chk("ack_busy", busy, 0);
        chk("ack_rdy", rx_ready, 1);
    endtask

    initial begin
        int e;

        tick;
        chk("rst_rdy", rx_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_valid", pkt_valid, 0);
        chk("rst_long", pkt_long, 0);
        chk("rst_err", pkt_err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", wr_addr, 0);
        n_rst = 1'b1;
        tick;
        chk("rel_rdy", rx_ready, 1);
        chk("rel_busy", busy, 0);

        // Ack in IDLE is ignored.
        pkt_ack = 1'b1;
        tick;
        pkt_ack = 1'b0;
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_rdy", rx_ready, 1);
        chk("idle_ack_valid", pkt_valid, 0);

        // Short packet, back-to-back payload.
        e = err_seen;
        send_type(8'hA5);
        send_payload(0, 62, 1'b0);
        expect_done(1'b0);
        chk("short_no_err", err_seen, e);

        // Long packet with rx_valid toggling.
        e = err_seen;
        send_type(8'h5A);
        send_payload(0, 111, 1'b1);
        expect_done(1'b1);
        chk("long_no_err", err_seen, e);

        // Bad type immediately followed by a good one; ack during RECV ignored.
        e = err_seen;
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        chk("bad_rdy", rx_ready, 1);
        tick;
        chk("bad_err", pkt_err, 1);
        chk("bad_code", err_code, 2'b01);
        chk("bad_busy", busy, 0);
        send_type(8'hA5);
        chk("bad_err_clr", pkt_err, 0);
        chk("bad_code_clr", err_code, 0);
        chk("bad_busy_recv", busy, 1);
        chk("bad_one_pulse", err_seen, e + 1);
        pkt_ack = 1'b1;
        tick;
        pkt_ack = 1'b0;
        chk("recv_ack_busy", busy, 1);
        chk("recv_ack_rdy", rx_ready, 1);
        chk("recv_ack_valid", pkt_valid, 0);
        send_payload(0, 62, 1'b0);
        expect_done(1'b0);
        chk("bad_total_err", err_seen, e + 1);

        // Timeout after 8 idle cycles.
        e = err_seen;
        send_type(8'h5A);
        send_payload(0, 5, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            chk("to_wait_busy", busy, 1);
            chk("to_wait_err", pkt_err, 0);
            if (k < 8) tick;
        end
        tick;
        chk("to_err", pkt_err, 1);
        chk("to_code", err_code, 2'b10);
        chk("to_busy", busy, 0);
        chk("to_valid", pkt_valid, 0);
        chk("to_q_drained", exp_q.size(), 0);
        tick;
        chk("to_err_clr", pkt_err, 0);
        chk("to_code_clr", err_code, 0);
        chk("to_one_pulse", err_seen, e + 1);

        // A byte on the 8th idle cycle beats the timeout.
        e = err_seen;
        send_type(8'h5A);
        send_payload(0, 5, 1'b0);
        repeat (7) tick;
        send_payload(5, 1, 1'b0);
        chk("late_err", pkt_err, 0);
        chk("late_busy", busy, 1);
        send_payload(6, 105, 1'b0);
        expect_done(1'b1);
        chk("late_no_err", err_seen, e);

        // Reset in the middle of a packet.
        e = err_seen;
        send_type(8'hA5);
        send_payload(0, 30, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 8'd30;
        n_rst    = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_rdy", rx_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", pkt_valid, 0);
        chk("mid_rst_err", pkt_err, 0);
        chk("mid_rst_addr", wr_addr, 0);
        chk("mid_rst_q", exp_q.size(), 0);
        rx_valid = 1'b0;
        tick;
        tick;
        n_rst = 1'b1;
        tick;
        chk("post_rst_rdy", rx_ready, 1);
        send_type(8'hA5);
        send_payload(0, 62, 1'b0);
        expect_done(1'b0);
        chk("rst_no_err", err_seen, e);

        tick;
        chk("final_q", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pd_rx_controller.md
Name: pd_rx_controller

Overview:
- Packet-decoder sequencer between the byte-wide receive interface and the header/target byte store.
- Consumes a type byte, then streams the payload bytes into the store with addresses from an internal byte counter.
- Detects the end of the packet from its type-dependent length, and supervises inter-byte timeout and bad-type errors.
- Holds off further input until the downstream consumer acknowledges each completed packet.

Parameters:
- TO_W, 16, width of the inter-byte timeout counter.
- TIMEOUT_CYCLES, 1000, idle cycles allowed between payload bytes before abort.
- TYPE_SHORT, 8'hA5, type byte of a short (target) packet: 62 payload bytes.
- TYPE_LONG, 8'h5A, type byte of a long (job) packet: 111 payload bytes.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid; a byte is accepted on a cycle with rx_valid & rx_ready
- rx_ready  out  1  controller can accept a byte
- wr_en  out  1  byte-store write strobe
- wr_addr  out  7  payload byte index, 0..110
- wr_data  out  8  payload byte
- pkt_valid  out  1  complete packet available; level, held until pkt_ack
- pkt_long  out  1  type of the held packet: 1 = long, 0 = short; valid while pkt_valid
- pkt_ack  in  1  consumer releases the packet
- pkt_err  out  1  one-cycle error pulse
- err_code  out  2  01 bad type, 10 timeout; valid while pkt_err, else 00
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values (asynchronous, active-low): state IDLE; rx_ready 0 on the reset cycle, 1 from the first clock after release; all other outputs 0; counters 0.
- IDLE: rx_ready=1.
  - Accepted byte == TYPE_SHORT or TYPE_LONG: latch pkt_long, clear the byte counter and timeout counter, go to RECV.
  - Any other accepted byte: pulse pkt_err with err_code=01 for 1 cycle, stay in IDLE.
- RECV: rx_ready=1. Each accepted byte is registered as wr_en=1, wr_addr=byte_count, wr_data=rx_data on the next cycle; byte_count then increments by 1.
  - Last byte (byte_count==61 short, ==110 long) goes to FLUSH.
  - The timeout counter increments on every cycle without an accepted byte and clears on each accepted byte.
  - If it reaches TIMEOUT_CYCLES-1 with no byte accepted, go to IDLE, pulse pkt_err with err_code=10, and clear the counters. No pkt_valid is raised.
- FLUSH: one cycle, rx_ready=0. The final write is on wr_en this cycle. Go to DONE.
- DONE: rx_ready=0, pkt_valid=1, pkt_long stable. On pkt_ack go to IDLE; pkt_valid drops the cycle after pkt_ack.
- Latency: last payload byte accepted in cycle N -> final wr_en in N+1 -> pkt_valid high from N+2.
- wr_en is only ever 1 for exactly one cycle per accepted payload byte. The type byte is never written.
- Byte counter is 7 bits and never wraps. The length check forces the exit to FLUSH before byte_count can exceed 110.
- pkt_ack outside DONE is ignored.
- A byte accepted in the same cycle the timeout would expire wins: the counter clears and there is no error.
- A bad-type pulse and the resulting IDLE stay are back-to-back capable: an erroneous byte followed immediately by a valid type byte starts RECV normally.
- Reset asserted mid-packet or in DONE discards everything: no pkt_err and no pkt_valid.
- busy = state != IDLE.

Decomposition:
- Shared package pd_pkg: state enum (IDLE, RECV, FLUSH, DONE), TYPE_SHORT/TYPE_LONG constants, SHORT_LAST=7'd61, LONG_LAST=7'd110, err_code localparams.
- One sub-module, pd_byte_counter: 7-bit counter with clear, count-enable and a last_byte flag selected by a long/short input. The timeout counter stays inline.

Test Plan:
- Short packet: 0xA5 then bytes 0x00..0x3D back-to-back -> 62 wr_en pulses with addr 0..61 and data equal to addr; pkt_valid 2 cycles after the last accept, pkt_long=0; rx_ready low until pkt_ack; pkt_valid low the cycle after ack.
- Long packet with rx_valid toggling every other cycle: 0x5A + 111 bytes -> addr 0..110 in order, no write gaps beyond the input gaps, pkt_long=1, no pkt_err.
- Bad type 0x33, then 0xA5 + 62 bytes -> one pkt_err pulse with err_code=01, no wr_en for 0x33, then a normal short packet.
- Timeout with TIMEOUT_CYCLES=8: 0x5A, 5 bytes, then rx_valid held low -> pkt_err with err_code=10 on the 8th idle cycle, busy=0 the next cycle. Repeat with a byte presented on the 8th idle cycle -> no error.
- Reset asserted at payload byte 30 -> all outputs 0 immediately. After release, a fresh 0xA5 packet writes from addr 0.
- pkt_ack pulsed while in IDLE and RECV -> no effect. rx_valid held high while in DONE -> no accept and no write until pkt_ack.
